// File: rtl/fec_conv_encoder.sv
// rtl/fec_conv_encoder.sv - rate-1/2 K=7 convolutional encoder (G1=171, G2=133) with ping-pong block buffers
// Option: FEC_TAILBITE_EN selects tail-biting preload; undefined gives zero-start encoding.
module fec_conv_encoder #(
    parameter int BLOCK_LEN = 96
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic DataInValid,
    input  logic DataIn,
    output logic DataInReady,
    output logic DataOutValid,
    output logic DataOutX,
    output logic DataOutY,
    output logic BlockStart,
    output logic BlockEnd
);
    localparam int IW = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ENCODE} state_t;

    logic [BLOCK_LEN-1:0] buf_q [2];
    logic [1:0]           full_q, full_d;
    logic                 wr_sel_q, rd_sel_q;
    logic [IW-1:0]        wr_idx_q, rd_idx_q;
    state_t               state_q;
    logic [5:0]           s_q, s_load;
    logic                 x_q, y_q, valid_q, start_q, end_q;
    logic                 accept, wr_last, rd_last, u, x_d, y_d;

    assign DataInReady  = Reset & Enable & ~full_q[wr_sel_q];
    assign accept       = DataInValid & DataInReady;
    assign wr_last      = (wr_idx_q == IW'(BLOCK_LEN - 1));
    assign rd_last      = (state_q == ST_ENCODE) && (rd_idx_q == IW'(BLOCK_LEN - 1));

    // s[0] holds the most recent previous input bit, s[5] the oldest
    assign u   = buf_q[rd_sel_q][rd_idx_q];
    assign x_d = u ^ s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[5];
    assign y_d = u ^ s_q[1] ^ s_q[2] ^ s_q[4] ^ s_q[5];

    always_comb begin
        s_load = '0;
`ifdef FEC_TAILBITE_EN
        for (int k = 0; k < 6; k++) begin
            s_load[k] = buf_q[rd_sel_q][BLOCK_LEN-1-k];
        end
`endif
    end

    // Set and clear target different buffers, so both may land on one edge
    always_comb begin
        full_d = full_q;
        if (accept && wr_last) full_d[wr_sel_q] = 1'b1;
        if (Enable && rd_last) full_d[rd_sel_q] = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (accept) buf_q[wr_sel_q][wr_idx_q] <= DataIn;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            state_q  <= ST_IDLE;
            s_q      <= '0;
            x_q      <= 1'b0;
            y_q      <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else if (Enable) begin
            full_q <= full_d;
            if (accept) begin
                if (wr_last) begin
                    wr_sel_q <= ~wr_sel_q;
                    wr_idx_q <= '0;
                end else begin
                    wr_idx_q <= wr_idx_q + IW'(1);
                end
            end
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_sel_q]) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    s_q      <= s_load;
                    rd_idx_q <= '0;
                    state_q  <= ST_ENCODE;
                end
                ST_ENCODE: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    valid_q <= 1'b1;
                    start_q <= (rd_idx_q == '0);
                    end_q   <= rd_last;
                    s_q     <= {s_q[4:0], u};
                    if (rd_last) begin
                        rd_sel_q <= ~rd_sel_q;
                        state_q  <= full_q[~rd_sel_q] ? ST_LOAD : ST_IDLE;
                    end else begin
                        rd_idx_q <= rd_idx_q + IW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DataOutValid = valid_q & Enable;
    assign DataOutX     = x_q;
    assign DataOutY     = y_q;
    assign BlockStart   = start_q;
    assign BlockEnd     = end_q;
endmodule
